id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage core: registers the decoded control bundle from main_control plus the operand/immediate data from decode.
- Performs load-use hazard detection against the instruction currently in EX.
- Inserts bubbles on hazard, flush or illegal opcode.
- Drives the upstream stall to the PC and IF/ID registers, and keeps bubble and illegal-opcode counters.

Parameters:
- XLEN, 32, datapath width for PC, register data and immediate.
- CNT_W, 16, width of the bubble and illegal-opcode counters (saturating).

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  7  instr[6:0]
- id_funct3  in  3  instr[14:12]
- id_funct7b5  in  1  instr[30]
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_pc  in  XLEN  PC of ID instruction
- id_rs1_data, id_rs2_data  in  XLEN  regfile read data
- id_imm  in  XLEN  sign-extended immediate
- id_alu_op  in  2  control bundle from main_control
- id_reg_write, id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_jump, id_jalr, id_branch, id_lui  in  1 each  control bundle from main_control
- ex_flush  in  1  EX redirect (taken branch/jump); kill ID instruction
- ex_hold  in  1  EX cannot accept (multi-cycle op); freeze the register
- hazard_stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  registered valid
- ex_* outputs  out  widths match the id_* inputs  registered copies of every id_* data and control input except id_valid
- illegal_op  out  1  one-cycle registered pulse: illegal opcode dropped
- bubble_cnt  out  CNT_W  bubbles inserted
- illegal_cnt  out  CNT_W  illegal opcodes seen

Behaviour:
- Reset (async, rst=1): all registered outputs are 0, including ex_valid, ex_alu_op=00, all counters and illegal_op.
- Legal opcodes: 51, 19, 3, 35, 111, 103, 99, 55, 23.
- rs1 is used for opcodes 51, 19, 3, 35, 103, 99.
- rs2 is used for opcodes 51, 35, 99.
- load_use = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
- hazard_stall = ~ex_flush & (ex_hold | load_use). It is combinational, and ex_flush masks it.
- Per-edge priority, highest first:
  1. ex_flush: load a bubble.
  2. ex_hold: keep all ex_* registers unchanged, no counter change.
  3. load_use: load a bubble; ID is re-presented next cycle by upstream.
  4. id_valid & illegal opcode: load a bubble, pulse illegal_op, illegal_cnt+1.
  5. id_valid: load all id_* fields, ex_valid=1.
  6. Otherwise: load a bubble, uncounted.
- Bubble = ex_valid=0, every 1-bit control output 0, ex_alu_op=00, all data and index fields 0.
- bubble_cnt increments on cases 1, 3 and 4. It saturates at all-ones and does not wrap.
- illegal_op is 0 in every cycle other than case 4.
- Latency: an accepted ID instruction appears on ex_* exactly one cycle later.
- Load-use costs exactly one bubble; the next cycle, ex_mem_read=0, so the stall clears.
- Simultaneous ex_flush and load_use: flush only, hazard_stall=0, one bubble counted.
- Simultaneous ex_hold and load_use: hold wins, hazard_stall=1, no bubble. The hazard is re-evaluated after the hold releases.
- rd=x0 never causes a stall.
- Reset asserted mid-stall clears everything immediately. hazard_stall falls as soon as the registered terms are 0.

Test Plan:
- Reset then idle: all outputs 0. Drive ADD (op 51, rd=5, rs1=1, rs2=2, alu_op=10, reg_write=1) -> next cycle ex_valid=1, ex_rd=5, ex_alu_op=10, hazard_stall=0.
- LW x7 followed by ADD x8,x7,x3 -> hazard_stall=1 for exactly one cycle, one bubble (ex_valid=0), ADD lands in EX one cycle later, bubble_cnt=1.
- LW x0 followed by use of x0, and LW x7 followed by LUI x9 (rs2 field=7, unused) -> no stall in either case.
- LW x7 followed by ADD x8,x7,x3 with ex_flush=1 on the same cycle -> hazard_stall=0, bubble loaded, bubble_cnt+1. With ex_hold=1 instead -> ex_* frozen, hazard_stall=1, bubble_cnt unchanged.
- Opcode 0x7F with id_valid=1 -> illegal_op pulse for one cycle, ex_valid=0, illegal_cnt=1. Drive 2^CNT_W+2 bubbles -> bubble_cnt holds at 0xFFFF.
- Assert rst asynchronously during an active load-use stall -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and saturating bubble / illegal-opcode counters.
module id_ex_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [6:0]       id_opcode,
   input  logic [2:0]       id_funct3,
   input  logic             id_funct7b5,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [1:0]       id_alu_op,
   input  logic             id_reg_write,
   input  logic             id_alu_src,
   input  logic             id_mem_read,
   input  logic             id_mem_write,
   input  logic             id_mem_to_reg,
   input  logic             id_jump,
   input  logic             id_jalr,
   input  logic             id_branch,
   input  logic             id_lui,
   input  logic             ex_flush,
   input  logic             ex_hold,
   output logic             hazard_stall,
   output logic             ex_valid,
   output logic [6:0]       ex_opcode,
   output logic [2:0]       ex_funct3,
   output logic             ex_funct7b5,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rs1_data,
   output logic [XLEN-1:0]  ex_rs2_data,
   output logic [XLEN-1:0]  ex_imm,
   output logic [1:0]       ex_alu_op,
   output logic             ex_reg_write,
   output logic             ex_alu_src,
   output logic             ex_mem_read,
   output logic             ex_mem_write,
   output logic             ex_mem_to_reg,
   output logic             ex_jump,
   output logic             ex_jalr,
   output logic             ex_branch,
   output logic             ex_lui,
   output logic             illegal_op,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] illegal_cnt
);

   typedef struct packed {
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic            funct7b5;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [1:0]      alu_op;
      logic            reg_write;
      logic            alu_src;
      logic            mem_read;
      logic            mem_write;
      logic            mem_to_reg;
      logic            jump;
      logic            jalr;
      logic            branch;
      logic            lui;
   } ex_bundle_t;

   ex_bundle_t       ex_d, ex_q, id_bundle;
   logic             ex_valid_d, ex_valid_q;
   logic             illegal_op_d, illegal_op_q;
   logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
   logic [CNT_W-1:0] illegal_cnt_d, illegal_cnt_q;
   logic             legal, uses_rs1, uses_rs2, load_use;

   always_comb begin
      legal    = 1'b0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      unique case (id_opcode)
         7'd51, 7'd35, 7'd99: begin
            legal    = 1'b1;
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         7'd19, 7'd3, 7'd103: begin
            legal    = 1'b1;
            uses_rs1 = 1'b1;
         end
         7'd111, 7'd55, 7'd23: legal = 1'b1;
         default: ;
      endcase
   end

   assign load_use = ex_valid_q & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid &
                     ((uses_rs1 & (ex_q.rd == id_rs1)) | (uses_rs2 & (ex_q.rd == id_rs2)));

   // Flush kills the ID instruction, so there is nothing left to stall for.
   assign hazard_stall = ~ex_flush & (ex_hold | load_use);

   always_comb begin
      id_bundle = '{opcode: id_opcode, funct3: id_funct3, funct7b5: id_funct7b5,
                    rs1: id_rs1, rs2: id_rs2, rd: id_rd, pc: id_pc,
                    rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
                    alu_op: id_alu_op, reg_write: id_reg_write, alu_src: id_alu_src,
                    mem_read: id_mem_read, mem_write: id_mem_write,
                    mem_to_reg: id_mem_to_reg, jump: id_jump, jalr: id_jalr,
                    branch: id_branch, lui: id_lui};
   end

   always_comb begin
      logic count_bubble;
      count_bubble  = 1'b0;
      ex_d          = '0;
      ex_valid_d    = 1'b0;
      illegal_op_d  = 1'b0;
      illegal_cnt_d = illegal_cnt_q;
      if (ex_flush) begin
         count_bubble = 1'b1;
      end else if (ex_hold) begin
         ex_d       = ex_q;
         ex_valid_d = ex_valid_q;
      end else if (load_use) begin
         count_bubble = 1'b1;
      end else if (id_valid && !legal) begin
         count_bubble = 1'b1;
         illegal_op_d = 1'b1;
         if (illegal_cnt_q != '1) illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
      end else if (id_valid) begin
         ex_d       = id_bundle;
         ex_valid_d = 1'b1;
      end
      bubble_cnt_d = bubble_cnt_q;
      if (count_bubble && bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q          <= '0;
         ex_valid_q    <= 1'b0;
         illegal_op_q  <= 1'b0;
         bubble_cnt_q  <= '0;
         illegal_cnt_q <= '0;
      end else begin
         ex_q          <= ex_d;
         ex_valid_q    <= ex_valid_d;
         illegal_op_q  <= illegal_op_d;
         bubble_cnt_q  <= bubble_cnt_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   assign ex_valid      = ex_valid_q;
   assign ex_opcode     = ex_q.opcode;
   assign ex_funct3     = ex_q.funct3;
   assign ex_funct7b5   = ex_q.funct7b5;
   assign ex_rs1        = ex_q.rs1;
   assign ex_rs2        = ex_q.rs2;
   assign ex_rd         = ex_q.rd;
   assign ex_pc         = ex_q.pc;
   assign ex_rs1_data   = ex_q.rs1_data;
   assign ex_rs2_data   = ex_q.rs2_data;
   assign ex_imm        = ex_q.imm;
   assign ex_alu_op     = ex_q.alu_op;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_alu_src    = ex_q.alu_src;
   assign ex_mem_read   = ex_q.mem_read;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_mem_to_reg = ex_q.mem_to_reg;
   assign ex_jump       = ex_q.jump;
   assign ex_jalr       = ex_q.jalr;
   assign ex_branch     = ex_q.branch;
   assign ex_lui        = ex_q.lui;
   assign illegal_op    = illegal_op_q;
   assign bubble_cnt    = bubble_cnt_q;
   assign illegal_cnt   = illegal_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed per-cycle vectors push expected
// observations; a negedge monitor pops and compares them.
module tb_id_ex_stage;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic             id_valid = 0, id_funct7b5 = 0, ex_flush = 0, ex_hold = 0;
   logic [6:0]       id_opcode = 0;
   logic [2:0]       id_funct3 = 0;
   logic [4:0]       id_rs1 = 0, id_rs2 = 0, id_rd = 0;
   logic [XLEN-1:0]  id_pc = 0, id_rs1_data = 0, id_rs2_data = 0, id_imm = 0;
   logic [1:0]       id_alu_op = 0;
   logic             id_reg_write = 0, id_alu_src = 0, id_mem_read = 0, id_mem_write = 0;
   logic             id_mem_to_reg = 0, id_jump = 0, id_jalr = 0, id_branch = 0, id_lui = 0;

   logic             hazard_stall, ex_valid, ex_funct7b5, illegal_op;
   logic [6:0]       ex_opcode;
   logic [2:0]       ex_funct3;
   logic [4:0]       ex_rs1, ex_rs2, ex_rd;
   logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [1:0]       ex_alu_op;
   logic             ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg;
   logic             ex_jump, ex_jalr, ex_branch, ex_lui;
   logic [CNT_W-1:0] bubble_cnt, illegal_cnt;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_alu_op(id_alu_op), .id_reg_write(id_reg_write),
      .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_mem_to_reg(id_mem_to_reg), .id_jump(id_jump), .id_jalr(id_jalr),
      .id_branch(id_branch), .id_lui(id_lui), .ex_flush(ex_flush), .ex_hold(ex_hold),
      .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
      .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_imm(ex_imm), .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write),
      .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
      .ex_branch(ex_branch), .ex_lui(ex_lui), .illegal_op(illegal_op),
      .bubble_cnt(bubble_cnt), .illegal_cnt(illegal_cnt)
   );

   typedef struct {
      logic        ev;
      logic [4:0]  rd;
      logic [1:0]  alu;
      logic        mr;
      logic        st;
      logic        ill;
      logic [15:0] bc;
      logic [15:0] ic;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Every valid instruction the bench drives has reg_write=1 and imm = A000_0000 | rd.
   always @(negedge clk) begin
      if (!rst && sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check("ex_valid", 32'(ex_valid), 32'(e.ev));
         check("ex_rd", 32'(ex_rd), 32'(e.rd));
         check("ex_alu_op", 32'(ex_alu_op), 32'(e.alu));
         check("ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
         check("ex_reg_write", 32'(ex_reg_write), 32'(e.ev));
         check("ex_imm", ex_imm, e.ev ? (32'hA000_0000 | 32'(e.rd)) : 32'h0);
         check("hazard_stall", 32'(hazard_stall), 32'(e.st));
         check("illegal_op", 32'(illegal_op), 32'(e.ill));
         check("bubble_cnt", 32'(bubble_cnt), 32'(e.bc));
         check("illegal_cnt", 32'(illegal_cnt), 32'(e.ic));
      end
   end

   // One cycle: apply ID/EX inputs just after the edge, push what the monitor must see
   // before the next edge (registered state from the last edge, stall from these inputs).
   task automatic step(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [1:0] alu,
                       input logic mr, input logic fl, input logic hd,
                       input logic ev, input logic [4:0] erd, input logic [1:0] ealu,
                       input logic emr, input logic est, input logic eill,
                       input logic [15:0] ebc, input logic [15:0] eic);
      exp_t e;
      @(posedge clk);
      #1;
      id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_alu_op = alu; id_reg_write = v; id_mem_read = mr; id_mem_to_reg = mr;
      id_alu_src = mr; id_imm = 32'hA000_0000 | 32'(rd); id_pc = 32'h100 + 32'(rd);
      ex_flush = fl; ex_hold = hd;
      e = '{ev: ev, rd: erd, alu: ealu, mr: emr, st: est, ill: eill, bc: ebc, ic: eic};
      sb.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #12;
      check("rst_ex_valid", 32'(ex_valid), 32'd0);
      check("rst_ex_alu_op", 32'(ex_alu_op), 32'd0);
      check("rst_stall", 32'(hazard_stall), 32'd0);
      #1 rst = 1'b0;

      //   v  op     rs1 rs2 rd alu mr fl hd | ev rd alu mr st ill bc ic
      step(0, 7'd0,  0,  0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 7'd51, 1,  2,  5, 2, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 7'd0,  0,  0,  0, 0, 0, 0, 0,   1, 5, 2, 0, 0, 0, 0, 0);
      // LW x7 then ADD x8,x7,x3: one stall, one bubble
      step(1, 7'd3,  1,  0,  7, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 7'd51, 7,  3,  8, 2, 0, 0, 0,   1, 7, 0, 1, 1, 0, 0, 0);
      step(1, 7'd51, 7,  3,  8, 2, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 7'd0,  0,  0,  0, 0, 0, 0, 0,   1, 8, 2, 0, 0, 0, 1, 0);
      // LW x0 then use of x0: no stall
      step(1, 7'd3,  1,  0,  0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 7'd51, 0,  0,  8, 2, 0, 0, 0,   1, 0, 0, 1, 0, 0, 1, 0);
      // LW x7 then LUI x9 with rs fields = 7: no stall
      step(1, 7'd3,  1,  0,  7, 0, 1, 0, 0,   1, 8, 2, 0, 0, 0, 1, 0);
      step(1, 7'd55, 7,  7,  9, 0, 0, 0, 0,   1, 7, 0, 1, 0, 0, 1, 0);
      // Load-use coinciding with flush: flush wins, stall masked
      step(1, 7'd3,  1,  0,  7, 0, 1, 0, 0,   1, 9, 0, 0, 0, 0, 1, 0);
      step(1, 7'd51, 7,  3,  8, 2, 0, 1, 0,   1, 7, 0, 1, 0, 0, 1, 0);
      // Load-use coinciding with hold: frozen, stall high, bubble only after release
      step(1, 7'd3,  1,  0,  7, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 2, 0);
      step(1, 7'd51, 7,  3,  8, 2, 0, 0, 1,   1, 7, 0, 1, 1, 0, 2, 0);
      step(1, 7'd51, 7,  3,  8, 2, 0, 0, 1,   1, 7, 0, 1, 1, 0, 2, 0);
      step(1, 7'd51, 7,  3,  8, 2, 0, 0, 0,   1, 7, 0, 1, 1, 0, 2, 0);
      step(1, 7'd51, 7,  3,  8, 2, 0, 0, 0,   0, 0, 0, 0, 0, 0, 3, 0);
      // Illegal opcode 0x7F
      step(1, 7'h7F, 1,  2,  4, 2, 0, 0, 0,   1, 8, 2, 0, 0, 0, 3, 0);
      step(0, 7'd0,  0,  0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 4, 1);
      step(0, 7'd0,  0,  0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 4, 1);
      // Set up a live load-use stall, then reset asynchronously mid-cycle
      step(1, 7'd3,  1,  0,  7, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 4, 1);
      step(1, 7'd51, 7,  3,  8, 2, 0, 0, 0,   1, 7, 0, 1, 1, 0, 4, 1);
      drain();
      #2 rst = 1'b1;
      #1;
      check("arst_ex_valid", 32'(ex_valid), 32'd0);
      check("arst_ex_rd", 32'(ex_rd), 32'd0);
      check("arst_ex_mem_read", 32'(ex_mem_read), 32'd0);
      check("arst_stall", 32'(hazard_stall), 32'd0);
      check("arst_bubble_cnt", 32'(bubble_cnt), 32'd0);
      check("arst_illegal_cnt", 32'(illegal_cnt), 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;

      // 2^CNT_W + 2 flush bubbles: counter must stick at all-ones
      id_valid = 1'b0;
      ex_flush = 1'b1;
      repeat ((1 << CNT_W) + 2) @(posedge clk);
      #1;
      check("bubble_sat", 32'(bubble_cnt), 32'hFFFF);
      check("sat_stall_masked", 32'(hazard_stall), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("bubble_sat_hold", 32'(bubble_cnt), 32'hFFFF);
      ex_flush = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
